// File: rtl/mem_port_b_arbiter.sv
// Round-robin arbiter for the memory stage's read-only port B.
// Requester 0 is the display pixel scanner, requester 1 the debug/dump reader.
// Accepted reads travel down a tag pipeline matched to the port B read latency,
// and each response is steered back to the requester that issued it.
// Optional feature: define ADDR_CHECK_EN to reject reads in the sine window
// (90000..90299) and at or above ADDR_LIMIT. A rejected read still gets a
// response, flagged with rsp_err and carrying zero data.
module mem_port_b_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int ADDR_LIMIT = 131071
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic [ADDR_W-1:0] addr_0,
  output logic              gnt_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_data_0,
  output logic              rsp_err_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_1,
  output logic              gnt_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_1,
  output logic              rsp_err_1,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic              busy
);

  localparam int SINE_LO = 90000;
  localparam int SINE_HI = 90299;

`ifdef ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // last_gnt = id of the most recently accepted requester; the other one wins a tie
  logic                  last_gnt;
  logic                  accept;
  logic                  acc_id;
  logic                  acc_err;
  logic [ADDR_W-1:0]     acc_addr;
  logic [31:0]           acc_addr_ext;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_id;
  logic [RD_LATENCY-1:0] pipe_err;
  logic                  out_valid;
  logic                  out_id;
  logic                  out_err;

  // Grant selection, accepted address and address legality check
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!rst) begin
      if (req_0 && req_1) begin
        gnt_0 = last_gnt;
        gnt_1 = !last_gnt;
      end else begin
        gnt_0 = req_0;
        gnt_1 = req_1;
      end
    end
    accept       = gnt_0 | gnt_1;
    acc_id       = gnt_1;
    acc_addr     = gnt_1 ? addr_1 : addr_0;
    acc_addr_ext = 32'(acc_addr);
    acc_err      = CHECK_EN &&
                   (((acc_addr_ext >= 32'(SINE_LO)) && (acc_addr_ext <= 32'(SINE_HI))) ||
                    (acc_addr_ext >= 32'(ADDR_LIMIT)));
  end

  // Round-robin state, port B address register and latency-matched tag pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      address_b  <= '0;
      pipe_valid <= '0;
      pipe_id    <= '0;
      pipe_err   <= '0;
    end else begin
      if (accept) begin
        last_gnt <= acc_id;
        // a rejected address never reaches the memory; port B keeps its last address
        if (!acc_err) address_b <= acc_addr;
      end
      pipe_valid[0] <= accept;
      pipe_id[0]    <= acc_id;
      pipe_err[0]   <= acc_err;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign out_valid = pipe_valid[RD_LATENCY-1];
  assign out_id    = pipe_id[RD_LATENCY-1];
  assign out_err   = pipe_err[RD_LATENCY-1];
  assign busy      = |pipe_valid;

  // Steer the returning read data to its owner; rsp_data holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_err_0   <= 1'b0;
      rsp_err_1   <= 1'b0;
      rsp_data_0  <= '0;
      rsp_data_1  <= '0;
    end else begin
      rsp_valid_0 <= out_valid & !out_id;
      rsp_valid_1 <= out_valid & out_id;
      rsp_err_0   <= out_valid & !out_id & out_err;
      rsp_err_1   <= out_valid & out_id & out_err;
      if (out_valid && !out_id) rsp_data_0 <= out_err ? '0 : read_data_b;
      if (out_valid && out_id)  rsp_data_1 <= out_err ? '0 : read_data_b;
    end
  end

endmodule
